// File: rtl/shift_add_mult.sv
// shift_add_mult: sequential shift-add multiplier for the MAC datapath.
// One partial product per clock for exactly WIDTH cycles after a start
// pulse, then a registered 2*WIDTH-bit product with a one-cycle done pulse.
// Optional build macro SHIFT_ADD_SIGNED_EN selects two's complement
// operands/product (magnitudes are multiplied and the sign applied at the end).
//
// Handshake: start is a request sampled only while IDLE; the operation is
// accepted on that edge. busy is high for the WIDTH iteration cycles; done
// pulses for one cycle when product is updated. start while busy is ignored.
module shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  // Current FSM state; kept as a named signal so checkers can bind to it.
  state_t state_q;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;
`ifdef SHIFT_ADD_SIGNED_EN
  logic             neg;
`endif

  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] shifted;
  logic             next_carry;
  logic [WIDTH-1:0] next_acc;
  logic [WIDTH-1:0] next_mplier;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  // One iteration step: conditional add of the multiplicand, then shift the
  // {carry,acc,mplier} chain right by one. carry is always 0 after a shift,
  // so using it as the sum's top input bit is the same as a zero extension.
  always_comb begin
    sum         = {carry, acc} + (mplier[0] ? {1'b0, mcand} : {1'b0, {WIDTH{1'b0}}});
    shifted     = {sum, mplier} >> 1;
    next_carry  = shifted[2*WIDTH];
    next_acc    = shifted[2*WIDTH-1:WIDTH];
    next_mplier = shifted[WIDTH-1:0];
  end

  // Operand conditioning at load: magnitudes in the signed build. The most
  // negative value maps to its own bit pattern, read as unsigned 2^(WIDTH-1).
  always_comb begin
`ifdef SHIFT_ADD_SIGNED_EN
    mag_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    mag_b = b[WIDTH-1] ? (~b + 1'b1) : b;
`else
    mag_a = a;
    mag_b = b;
`endif
  end

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
`ifdef SHIFT_ADD_SIGNED_EN
      neg     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand   <= mag_a;
            mplier  <= mag_b;
            acc     <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b1;
            state_q <= CALC;
`ifdef SHIFT_ADD_SIGNED_EN
            neg     <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
          end
        end
        CALC: begin
          carry  <= next_carry;
          acc    <= next_acc;
          mplier <= next_mplier;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
`ifdef SHIFT_ADD_SIGNED_EN
            product <= neg ? (~{next_acc, next_mplier} + 1'b1) : {next_acc, next_mplier};
`else
            product <= {next_acc, next_mplier};
`endif
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// tb_shift_add_mult: directed bench for shift_add_mult (WIDTH=8).
// Define SHIFT_ADD_SIGNED_EN for both files to exercise the signed build.
module tb_shift_add_mult;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_vec;
  int n_err;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_prod;

  shift_add_mult #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; return 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Driver: present a one-cycle start; optionally register the expected result.
  task automatic start_op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic [2*W-1:0] e, input bit push);
    a     = aa;
    b     = bb;
    start = 1'b1;
    if (push) exp_q.push_back(e);
    tick();
    start = 1'b0;
    a     = W'($urandom_range(0, 255));
    b     = W'($urandom_range(0, 255));
  endtask

  // Expect busy for W cycles; at busy cycle poke_at (1-based) pulse a start to be ignored.
  task automatic busy_phase(input string tag, input int poke_at);
    for (int i = 1; i <= W; i++) begin
      check({tag, " busy"}, {15'd0, busy}, 16'd1);
      check({tag, " done_low"}, {15'd0, done}, 16'd0);
      if (i == poke_at) begin
        start = 1'b1;
        a     = 8'd2;
        b     = 8'd3;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
  endtask

  // Scoreboard: the done cycle must carry the oldest expected product.
  task automatic done_phase(input string tag);
    logic [2*W-1:0] e;
    check({tag, " done"}, {15'd0, done}, 16'd1);
    check({tag, " busy_low"}, {15'd0, busy}, 16'd0);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s scoreboard empty observed=0x%0h expected=none", tag, product);
    end else begin
      e = exp_q.pop_front();
      check({tag, " product"}, product, e);
      last_prod = e;
    end
  endtask

  task automatic after_phase(input string tag);
    tick();
    check({tag, " done_pulse_end"}, {15'd0, done}, 16'd0);
    check({tag, " product_hold"}, product, last_prod);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    last_prod = '0;
    rst       = 1'b1;
    start     = 1'b0;
    a         = '0;
    b         = '0;

    // 1: reset and idle
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle busy", {15'd0, busy}, 16'd0);
      check("idle done", {15'd0, done}, 16'd0);
      check("idle product", product, 16'h0000);
    end

`ifndef SHIFT_ADD_SIGNED_EN
    // 2: 13*11
    start_op(8'd13, 8'd11, 16'd143, 1'b1);
    busy_phase("13x11", 0);
    done_phase("13x11");
    after_phase("13x11");
    tick();
    check("13x11 hold2", product, 16'd143);

    // 3: max operands, then zero operand still takes W cycles
    start_op(8'd255, 8'd255, 16'hFE01, 1'b1);
    busy_phase("255x255", 0);
    done_phase("255x255");
    after_phase("255x255");
    start_op(8'd0, 8'd200, 16'h0000, 1'b1);
    busy_phase("0x200", 0);
    done_phase("0x200");
    after_phase("0x200");

    // 4: start while busy ignored; start in done cycle accepted
    start_op(8'd9, 8'd7, 16'd63, 1'b1);
    busy_phase("9x7", 3);
    done_phase("9x7");
    start_op(8'd4, 8'd5, 16'd20, 1'b1);
    check("4x5 done_low_at_accept", {15'd0, done}, 16'd0);
    busy_phase("4x5", 0);
    done_phase("4x5");
    after_phase("4x5");

    // unsigned interpretation of 0xFD
    start_op(8'hFD, 8'd5, 16'h04F1, 1'b1);
    busy_phase("u_fdx5", 0);
    done_phase("u_fdx5");
    after_phase("u_fdx5");
`else
    start_op(8'hFD, 8'd5, 16'hFFF1, 1'b1);
    busy_phase("s_m3x5", 0);
    done_phase("s_m3x5");
    after_phase("s_m3x5");
    start_op(8'h80, 8'h80, 16'h4000, 1'b1);
    busy_phase("s_80x80", 0);
    done_phase("s_80x80");
    after_phase("s_80x80");
    start_op(8'h80, 8'h7F, 16'hC080, 1'b1);
    busy_phase("s_80x7f", 0);
    done_phase("s_80x7f");
    after_phase("s_80x7f");
    start_op(8'd13, 8'd11, 16'd143, 1'b1);
    busy_phase("s_13x11", 0);
    done_phase("s_13x11");
    after_phase("s_13x11");
`endif

    // 5: asynchronous reset mid-operation discards the result
    start_op(8'd100, 8'd100, 16'd0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      check("abort busy", {15'd0, busy}, 16'd1);
      tick();
    end
    check("abort busy4", {15'd0, busy}, 16'd1);
    rst = 1'b1;
    #1;
    check("abort rst busy", {15'd0, busy}, 16'd0);
    check("abort rst done", {15'd0, done}, 16'd0);
    check("abort rst product", product, 16'h0000);
    #2;
    rst = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      tick();
      check("abort no_done", {15'd0, done}, 16'd0);
      check("abort no_busy", {15'd0, busy}, 16'd0);
    end
    start_op(8'd7, 8'd6, 16'd42, 1'b1);
    busy_phase("7x6", 0);
    done_phase("7x6");
    after_phase("7x6");

    check("scoreboard drained", 16'(exp_q.size()), 16'd0);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
